// File: rtl/ring_token_monitor_if.sv
// Connection bundle between a one-hot ring counter tap and the token monitor.
// The master side supplies the sampled ring stages and the clear strobe; the slave reports status.
interface ring_token_monitor_if #(
    parameter int WIDTH = 4,
    parameter int REV_W = 8,
    parameter int ERR_W = 4
);
    localparam int POS_W = $clog2(WIDTH);

    logic [WIDTH-1:0] ring_in;
    logic             clr;
    logic [POS_W-1:0] pos;
    logic             pos_vld;
    logic             rev_tick;
    logic [REV_W-1:0] rev_cnt;
    logic             locked;
    logic             err;
    logic             err_sticky;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output ring_in,
        output clr,
        input  pos,
        input  pos_vld,
        input  rev_tick,
        input  rev_cnt,
        input  locked,
        input  err,
        input  err_sticky,
        input  err_cnt
    );

    modport slave (
        input  ring_in,
        input  clr,
        output pos,
        output pos_vld,
        output rev_tick,
        output rev_cnt,
        output locked,
        output err,
        output err_sticky,
        output err_cnt
    );
endinterface

// File: rtl/ring_token_monitor.sv
// Observes a one-hot ring counter, encodes the token position, checks single-stage advance,
// counts revolutions, declares lock after clean revolutions and logs ring-rule violations.
module ring_token_monitor #(
    parameter int WIDTH    = 4,
    parameter int REV_W    = 8,
    parameter int ERR_W    = 4,
    parameter int LOCK_CNT = 2
) (
    input  logic                clk,
    input  logic                n_rst,
    ring_token_monitor_if.slave mon
);
    localparam int POS_W = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int GR_W  = 4;

    localparam logic [POS_W-1:0] LAST_POS = POS_W'(WIDTH - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;
    localparam logic [GR_W-1:0]  LOCK_TGT = GR_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CLS_ZERO  = 2'd0,
        CLS_ONE   = 2'd1,
        CLS_MULTI = 2'd2
    } class_e;

    state_e           state_q, state_d;
    logic [POS_W-1:0] prev_pos_q, prev_pos_d;
    logic [GR_W-1:0]  good_rev_q, good_rev_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             pos_vld_q, pos_vld_d;
    logic             rev_tick_q, rev_tick_d;
    logic [REV_W-1:0] rev_cnt_q, rev_cnt_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             err_sticky_q, err_sticky_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic [CNT_W-1:0] bit_cnt;
    logic [POS_W-1:0] one_idx;
    class_e           cls;
    logic [POS_W-1:0] next_pos;
    logic             step_wraps;
    logic             good_step;

    // Population count plus the index of the set bit; the index is only meaningful for CLS_ONE.
    always_comb begin
        bit_cnt = '0;
        one_idx = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (mon.ring_in[k]) begin
                bit_cnt = bit_cnt + CNT_W'(1);
                one_idx = POS_W'(k);
            end
        end
        if (bit_cnt == '0) begin
            cls = CLS_ZERO;
        end else if (bit_cnt == CNT_W'(1)) begin
            cls = CLS_ONE;
        end else begin
            cls = CLS_MULTI;
        end
    end

    // Explicit modulo so non-power-of-two rings wrap at WIDTH-1.
    assign step_wraps = (prev_pos_q == LAST_POS);
    assign next_pos   = step_wraps ? '0 : prev_pos_q + POS_W'(1);
    assign good_step  = (cls == CLS_ONE) && (one_idx == next_pos);

    // FSM next-state and token tracking.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d    = state_q;
        prev_pos_d = prev_pos_q;
        good_rev_d = good_rev_q;
        rev_tick_d = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cls == CLS_ONE) begin
                    state_d    = ST_TRACK;
                    prev_pos_d = one_idx;
                end else if (cls == CLS_MULTI) begin
                    err_d = 1'b1;
                end
            end
            ST_TRACK, ST_LOCKED: begin
                if (good_step) begin
                    prev_pos_d = one_idx;
                    if (step_wraps) begin
                        rev_tick_d = 1'b1;
                        if (good_rev_q < LOCK_TGT) begin
                            good_rev_d = good_rev_q + GR_W'(1);
                        end
                    end
                    if (good_rev_d == LOCK_TGT) begin
                        state_d = ST_LOCKED;
                    end
                end else begin
                    err_d      = 1'b1;
                    good_rev_d = '0;
                    if (cls == CLS_ONE) begin
                        state_d    = ST_TRACK;
                        prev_pos_d = one_idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                good_rev_d = '0;
            end
        endcase

        locked_d = (state_d == ST_LOCKED);
    end

    // Position encode, revolution and error bookkeeping; clr overrides same-cycle updates.
    always_comb begin
        pos_d        = pos_q;
        pos_vld_d    = (cls == CLS_ONE);
        rev_cnt_d    = rev_cnt_q;
        err_cnt_d    = err_cnt_q;
        err_sticky_d = err_sticky_q;

        if (cls == CLS_ONE) begin
            pos_d = one_idx;
        end
        if (rev_tick_d) begin
            rev_cnt_d = rev_cnt_q + REV_W'(1);
        end
        if (err_d) begin
            err_sticky_d = 1'b1;
            if (err_cnt_q != ERR_MAX) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end
        end
        if (mon.clr) begin
            rev_cnt_d    = '0;
            err_cnt_d    = '0;
            err_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            prev_pos_q   <= '0;
            good_rev_q   <= '0;
            pos_q        <= '0;
            pos_vld_q    <= 1'b0;
            rev_tick_q   <= 1'b0;
            rev_cnt_q    <= '0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of the others.
            state_q      <= state_d;
            prev_pos_q   <= prev_pos_d;
            good_rev_q   <= good_rev_d;
            pos_q        <= pos_d;
            pos_vld_q    <= pos_vld_d;
            rev_tick_q   <= rev_tick_d;
            rev_cnt_q    <= rev_cnt_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign mon.pos        = pos_q;
    assign mon.pos_vld    = pos_vld_q;
    assign mon.rev_tick   = rev_tick_q;
    assign mon.rev_cnt    = rev_cnt_q;
    assign mon.locked     = locked_q;
    assign mon.err        = err_q;
    assign mon.err_sticky = err_sticky_q;
    assign mon.err_cnt    = err_cnt_q;

endmodule
